neopixel_decoder: RTL and testbench
===================================

# neopixel_decoder

Receive-side decoder for the WS2812/NeoPixel one-wire protocol, the inverse of our bitstream driver. It samples the serial line, classifies each high pulse as a 0 or 1 bit by its width, and assembles 24-bit GRB pixel words. It reports a frame latch when it detects a reset-length low period. It is used in loopback verification of the transmitter and as the input stage for chained controllers.

## Interface
Parameters:
- BIT_THRESH, 26: minimum high width in cycles that decodes as bit 1. Narrower pulses decode as 0.
- MAX_HIGH, 50: a high width reaching this many cycles is a protocol error.
- RESET_CYCLES, 2500: low width in cycles that constitutes a latch (50 µs at 50 MHz).
- IDX_W, 8: width of pixel_index.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: reset, asynchronous, active-high. Clock is clock.
- din, in, 1: serial line, asynchronous to clock.
- pixel, out, 24: last decoded word, {G[7:0], R[7:0], B[7:0]}, MSB received first.
- pixel_valid, out, 1: one-cycle pulse when pixel updates.
- pixel_index, out, IDX_W: position of pixel within the current frame. First pixel is 0. Saturates at all-ones.
- latch, out, 1: one-cycle pulse at end of frame.
- error, out, 1: one-cycle pulse on a protocol error.

## Operation
- din passes through a 2-flop synchronizer to give din_s. A third flop holds din_s delayed, for edge detection. All control logic uses din_s only.
- High width W is the number of consecutive cycles din_s = 1. Bit value = (W ≥ BIT_THRESH).
- States:
  - S_LOW: counts low cycles in lcnt, saturating at RESET_CYCLES. A din_s rise clears hcnt to 1 and goes to S_HIGH.
  - S_HIGH: hcnt increments each cycle din_s = 1.
    - On din_s = 0: the bit is shifted into shreg, bitcnt increments, lcnt is set to 1, and the state goes to S_LOW.
    - If hcnt reaches MAX_HIGH while din_s = 1: pulse error, clear bitcnt (partial word discarded), go to S_STUCK.
  - S_STUCK: waits for din_s = 0, then goes to S_LOW with lcnt = 1. A stuck-high line produces only one error.
- Word completion: when the 24th bit is shifted in:
  - pixel ← {shreg[22:0], bit}.
  - pixel_valid pulses.
  - pixel_index ← frame count. Frame count then increments, saturating.
  - bitcnt ← 0.
- Latch: when lcnt reaches RESET_CYCLES and the frame is active (frame count ≠ 0 or bitcnt ≠ 0):
  - Pulse latch.
  - If bitcnt ≠ 0, pulse error in the same cycle and discard the partial word.
  - Clear bitcnt and frame count.
  - Fires at most once per low period. Continued low with an inactive frame produces nothing.
- pixel holds its value until the next completed word. It is not cleared by latch.
- Reset (any time, including mid-word):
  - State becomes S_LOW.
  - All counters, shreg, and synchronizer flops become 0.
  - Outputs: pixel = 0, pixel_valid = 0, pixel_index = 0, latch = 0, error = 0.
  - No latch is reported after reset until new bits arrive.
- Counter widths: hcnt is $clog2(MAX_HIGH+1), lcnt is $clog2(RESET_CYCLES+1), bitcnt is 5 bits.

## Timing
- All outputs are registered.
- The first clock edge at which the first synchronizer flop samples din = 0 at the end of the 24th bit is edge k. pixel_valid is high in the cycle following edge k+2.
- latch and its accompanying error assert 2 edges after the edge at which din_s would show the RESET_CYCLES-th consecutive low sample.
- The error for MAX_HIGH asserts in the cycle after hcnt reaches MAX_HIGH.
- pixel_valid and latch never assert in the same cycle, because a latch requires ≥ RESET_CYCLES − 1 cycles of low after the last bit.
- Minimum supported low between bits: 1 cycle of din_s.

## Structure
- neopixel_pkg holds:
  - the state enum (S_LOW, S_HIGH, S_STUCK);
  - a packed struct pixel_t {g, r, b} of 8 bits each;
  - default timing constants for 50 MHz: T0H = 18, T1H = 35, TBIT = 62, TRESET = 2500.
- Sub-module sync_edge: 2-flop synchronizer plus delay flop, with outputs din_s, rise, fall.
- The frame counter and output holding use library counter/register instances.

## Test plan
1. Reset, then din low for 3000 cycles → all outputs stay 0, no latch.
2. One word 24'hFF0080 sent with 1 = 35-cycle high and 0 = 18-cycle high, 62-cycle period → single pixel_valid with pixel = 24'hFF0080, pixel_index = 0.
3. Words 24'h123456 then 24'hABCDEF, then 2500 cycles low → pixel_index 0 then 1, one latch, no error. The next frame's first word has pixel_index = 0.
4. Threshold check: a word whose MSB high width is 25 and another whose MSB high width is 26 → MSBs decode as 0 and 1 respectively.
5. High held for 60 cycles after 5 bits → error pulses once, at W = 50. No pixel_valid is produced. The following full word 24'h00FF00 decodes correctly.
6. 10 bits then 2500 cycles low → latch and error in the same cycle, no pixel_valid. Separately, asserting reset mid-word → all outputs are 0 the next cycle, and the next 24 bits form a clean word.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared types and 50 MHz timing defaults for the NeoPixel receive path.
package neopixel_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_HIGH,
        S_STUCK
    } state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    localparam int T0H    = 18;
    localparam int T1H    = 35;
    localparam int TBIT   = 62;
    localparam int TRESET = 2500;

endpackage

// File: rtl/neopixel_decoder_sync_edge.sv
// Two-flop synchronizer for the serial line plus one delay flop for edge detection.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign din_s = sync;
    assign rise  = sync & ~dly;
    assign fall  = ~sync & dly;

endmodule

// File: rtl/neopixel_decoder.sv
// WS2812 receive decoder: classifies high pulses by width, assembles 24-bit GRB
// words, and flags frame latches and protocol errors.
module neopixel_decoder
    import neopixel_pkg::*;
#(
    parameter int BIT_THRESH   = 26,
    parameter int MAX_HIGH     = 50,
    parameter int RESET_CYCLES = 2500,
    parameter int IDX_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             din,
    output logic [23:0]      pixel,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             latch,
    output logic             error
);

    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    localparam logic [HW-1:0] TH_H     = HW'(BIT_THRESH);
    localparam logic [HW-1:0] HIGH_MAX = HW'(MAX_HIGH);
    localparam logic [HW-1:0] HIGH_END = HW'(MAX_HIGH - 1);
    localparam logic [LW-1:0] LOW_MAX  = LW'(RESET_CYCLES);

    logic din_s;
    logic rise;
    logic fall;

    sync_edge u_sync (
        .clock (clock),
        .reset (reset),
        .din   (din),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    state_t           state;
    logic [HW-1:0]    hcnt;
    logic [LW-1:0]    lcnt;
    logic [4:0]       bitcnt;
    logic [22:0]      shreg;
    logic [IDX_W-1:0] fcnt;
    pixel_t           pix_q;

    logic             bit_val;
    logic [23:0]      word_next;
    logic             frame_active;

    assign bit_val      = (hcnt >= TH_H);
    assign word_next    = {shreg, bit_val};
    assign frame_active = (fcnt != '0) || (bitcnt != '0);
    assign pixel        = pix_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_LOW;
            hcnt        <= '0;
            lcnt        <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            fcnt        <= '0;
            pix_q       <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            latch       <= 1'b0;
            error       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            latch       <= 1'b0;
            error       <= 1'b0;

            case (state)
                S_LOW: begin
                    // Latch check looks at the registered count, so it fires once
                    // and then the cleared frame keeps it quiet for the rest of the low.
                    if (lcnt == LOW_MAX && frame_active) begin
                        latch  <= 1'b1;
                        error  <= (bitcnt != '0);
                        bitcnt <= '0;
                        fcnt   <= '0;
                    end
                    if (rise) begin
                        hcnt  <= HW'(1);
                        state <= S_HIGH;
                    end else if (lcnt != LOW_MAX) begin
                        lcnt <= lcnt + 1'b1;
                    end
                end

                S_HIGH: begin
                    if (fall) begin
                        shreg <= word_next[22:0];
                        lcnt  <= LW'(1);
                        state <= S_LOW;
                        if (bitcnt == 5'd23) begin
                            pix_q       <= pixel_t'(word_next);
                            pixel_valid <= 1'b1;
                            pixel_index <= fcnt;
                            if (fcnt != '1) begin
                                fcnt <= fcnt + 1'b1;
                            end
                            bitcnt <= '0;
                        end else begin
                            bitcnt <= bitcnt + 5'd1;
                        end
                    end else if (hcnt == HIGH_END) begin
                        error  <= 1'b1;
                        bitcnt <= '0;
                        hcnt   <= HIGH_MAX;
                        state  <= S_STUCK;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                S_STUCK: begin
                    if (!din_s) begin
                        lcnt  <= LW'(1);
                        state <= S_LOW;
                    end
                end

                default: state <= S_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_decoder.sv
// Scoreboard bench for neopixel_decoder: expected events are queued as stimulus
// is driven and matched (value and cycle) as the decoder emits them.
module tb_neopixel_decoder;

    localparam int RST  = 2500;
    localparam int MAXH = 50;
    localparam int PER  = 62;
    localparam int H1   = 35;
    localparam int H0   = 18;

    typedef struct {
        logic        pv;
        logic        lt;
        logic        er;
        logic [23:0] pixel;
        logic [7:0]  index;
        int          cyc;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        latch;
    logic        error;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   events    = 0;
    int   last_rise = 0;
    int   last_fall = 0;
    ev_t  sb[$];
    ev_t  e;

    neopixel_decoder #(
        .BIT_THRESH   (26),
        .MAX_HIGH     (MAXH),
        .RESET_CYCLES (RST),
        .IDX_W        (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .din         (din),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .latch       (latch),
        .error       (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset && (pixel_valid || latch || error)) begin
            events++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got pv=%b lt=%b er=%b pix=%h idx=%0d cyc=%0d, expected no event",
                         pixel_valid, latch, error, pixel, pixel_index, cyc);
            end else begin
                e = sb.pop_front();
                if (pixel_valid !== e.pv || latch !== e.lt || error !== e.er ||
                    (e.pv && (pixel !== e.pixel || pixel_index !== e.index)) ||
                    (e.cyc != 0 && cyc != e.cyc)) begin
                    failures++;
                    $display("FAIL scoreboard got pv=%b lt=%b er=%b pix=%h idx=%0d cyc=%0d, expected pv=%b lt=%b er=%b pix=%h idx=%0d cyc=%0d",
                             pixel_valid, latch, error, pixel, pixel_index, cyc,
                             e.pv, e.lt, e.er, e.pixel, e.index, e.cyc);
                end
            end
        end
    end

    // Called at posedge+1; leaves at posedge+1 exactly 'period' cycles later.
    task automatic pulse(input int h, input int period);
        din = 1'b1;
        last_rise = cyc;
        repeat (h) @(posedge clock);
        #1;
        din = 1'b0;
        last_fall = cyc;
        repeat (period - h) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 23; i > 23 - n; i--) pulse(w[i] ? H1 : H0, PER);
    endtask

    task automatic send_word(input logic [23:0] w, input logic [23:0] exp_w,
                             input logic [7:0] idx, input int msb_h);
        ev_t x;
        int  h;
        x.pv = 1'b1; x.lt = 1'b0; x.er = 1'b0;
        x.pixel = exp_w; x.index = idx;
        x.cyc = cyc + 23 * PER + (w[0] ? H1 : H0) + 3;
        sb.push_back(x);
        for (int i = 23; i >= 0; i--) begin
            h = w[i] ? H1 : H0;
            if (i == 23 && msb_h != 0) h = msb_h;
            pulse(h, PER);
        end
    endtask

    task automatic idle_latch(input logic err);
        ev_t x;
        x.pv = 1'b0; x.lt = 1'b1; x.er = err;
        x.pixel = '0; x.index = '0;
        x.cyc = last_fall + RST + 3;
        sb.push_back(x);
        repeat (RST + 50) @(posedge clock);
        #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        int ev0;
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({pixel, pixel_valid, pixel_index, latch, error} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got pix=%h pv=%b idx=%0d lt=%b er=%b expected all 0",
                     pixel, pixel_valid, pixel_index, latch, error);
        end
        ev0 = events;
        @(posedge clock);
        #1;
        repeat (3000) @(posedge clock);
        #1;
        checks++;
        if (events !== ev0 || pixel !== 24'd0) begin
            failures++;
            $display("FAIL reset_idle got events=%0d pix=%h expected events=%0d pix=0",
                     events - ev0, pixel, 0);
        end
    endtask

    task automatic test_single_word;
        send_word(24'hFF0080, 24'hFF0080, 8'd0, 0);
        idle_latch(1'b0);
        check_drained("single_word");
    endtask

    task automatic test_back_to_back;
        send_word(24'h123456, 24'h123456, 8'd0, 0);
        send_word(24'hABCDEF, 24'hABCDEF, 8'd1, 0);
        idle_latch(1'b0);
        checks++;
        if (pixel !== 24'hABCDEF) begin
            failures++;
            $display("FAIL pixel_hold got %h expected %h", pixel, 24'hABCDEF);
        end
        send_word(24'h5A5A5A, 24'h5A5A5A, 8'd0, 0);
        idle_latch(1'b0);
        check_drained("back_to_back");
    endtask

    task automatic test_threshold;
        send_word(24'h800001, 24'h000001, 8'd0, 25);
        send_word(24'h800001, 24'h800001, 8'd1, 26);
        idle_latch(1'b0);
        check_drained("threshold");
    endtask

    task automatic test_stuck_high;
        ev_t x;
        send_bits(24'hA80000, 5);
        x.pv = 1'b0; x.lt = 1'b0; x.er = 1'b1;
        x.pixel = '0; x.index = '0;
        x.cyc = cyc + MAXH + 2;
        sb.push_back(x);
        pulse(60, 104);
        send_word(24'h00FF00, 24'h00FF00, 8'd0, 0);
        idle_latch(1'b0);
        check_drained("stuck_high");
    endtask

    task automatic test_partial_and_reset;
        send_bits(24'hF0F0F0, 10);
        idle_latch(1'b1);
        check_drained("partial_latch");
        send_bits(24'h0F0F0F, 10);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({pixel, pixel_valid, pixel_index, latch, error} !== 35'd0) begin
            failures++;
            $display("FAIL midword_reset got pix=%h pv=%b idx=%0d lt=%b er=%b expected all 0",
                     pixel, pixel_valid, pixel_index, latch, error);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        send_word(24'hC3A55A, 24'hC3A55A, 8'd0, 0);
        idle_latch(1'b0);
        check_drained("reset_word");
    endtask

    initial begin
        din   = 1'b0;
        reset = 1'b0;
        #1;
        test_reset;
        test_single_word;
        test_back_to_back;
        test_threshold;
        test_stuck_high;
        test_partial_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
